// File: rtl/gpio_intr_gen.sv
// gpio_intr_gen: synchronises raw GPIO pads, applies an optional per-pin
// debounce filter, and emits registered one-cycle edge-event pulses that feed
// the GPIO register block's interrupt status. Also exports the filtered level.
//
// state | meaning
// ------+------------------------------------------------------------------
// INIT  | synchroniser settling; init_cnt counts 0..2, events forced low
// RUN   | prescaler, debounce and edge detection active until h_reset

module gpio_intr_gen #(
   parameter int WD      = 32,
   parameter int DEB_W   = 4,
   parameter int PRESC_W = 16
) (
   input  logic               mclk,
   input  logic               h_reset,
   input  logic [WD-1:0]      gpio_in_data,
   input  logic [WD-1:0]      cfg_deb_en,
   input  logic [PRESC_W-1:0] cfg_deb_presc,
   input  logic [DEB_W-1:0]   cfg_deb_cnt,
   input  logic [WD-1:0]      cfg_gpio_posedge_int_sel,
   input  logic [WD-1:0]      cfg_gpio_negedge_int_sel,
   output logic [WD-1:0]      gpio_filt_data,
   output logic [WD-1:0]      gpio_int_event,
   output logic               gen_ready
);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [DEB_W-1:0]   DEB_ONE   = DEB_W'(1);
   localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

   state_t             state;
   logic [1:0]         init_cnt;
   logic [WD-1:0]      sync_s;
   logic [WD-1:0]      sync_ss;
   logic [WD-1:0]      filt;
   logic [WD-1:0]      filt_d;
   logic [DEB_W-1:0]   deb_cnt [WD];
   logic [PRESC_W-1:0] presc_cnt;
   logic               tick;
   logic               init_done;

   assign init_done      = (state == ST_INIT) && (init_cnt == 2'd2);
   assign gpio_filt_data = filt;

   // Debounce tick; >= lets a lowered period wrap immediately instead of overflowing
   always_comb begin
      tick = 1'b0;
      if (state == ST_RUN && presc_cnt >= cfg_deb_presc) begin
         tick = 1'b1;
      end
   end

   // Two-flop synchroniser for the asynchronous pad inputs, runs in every state
   always_ff @(posedge mclk) begin
      if (h_reset) begin
         sync_s  <= '0;
         sync_ss <= '0;
      end else begin
         sync_s  <= gpio_in_data;
         sync_ss <= sync_s;
      end
   end

   // Sequencing FSM: hold off for synchroniser settling, then run
   always_ff @(posedge mclk) begin
      if (h_reset) begin
         state     <= ST_INIT;
         init_cnt  <= 2'd0;
         gen_ready <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               if (init_cnt == 2'd2) begin
                  gen_ready <= 1'b1;
                  state     <= ST_RUN;
               end else begin
                  init_cnt <= init_cnt + 2'd1;
               end
            end
            ST_RUN: begin
               state <= ST_RUN;
            end
            default: begin
               state <= ST_INIT;
            end
         endcase
      end
   end

   // Shared debounce prescaler
   always_ff @(posedge mclk) begin
      if (h_reset) begin
         presc_cnt <= '0;
      end else if (state == ST_RUN) begin
         if (tick) begin
            presc_cnt <= '0;
         end else begin
            presc_cnt <= presc_cnt + PRESC_ONE;
         end
      end
   end

   // Per-pin debounce filter; INIT exit seeds the filter from the settled input
   always_ff @(posedge mclk) begin
      if (h_reset) begin
         filt <= '0;
         for (int i = 0; i < WD; i++) begin
            deb_cnt[i] <= '0;
         end
      end else if (init_done) begin
         filt <= sync_ss;
      end else if (state == ST_RUN) begin
         for (int i = 0; i < WD; i++) begin
            if (!cfg_deb_en[i]) begin
               filt[i]    <= sync_ss[i];
               deb_cnt[i] <= '0;
            end else if (sync_ss[i] == filt[i]) begin
               deb_cnt[i] <= '0;
            end else if (tick) begin
               if (deb_cnt[i] >= cfg_deb_cnt) begin
                  filt[i]    <= sync_ss[i];
                  deb_cnt[i] <= '0;
               end else if (deb_cnt[i] != '1) begin
                  deb_cnt[i] <= deb_cnt[i] + DEB_ONE;
               end
            end
         end
      end
   end

   // Edge detection on the filtered level; events suppressed until RUN
   always_ff @(posedge mclk) begin
      if (h_reset) begin
         filt_d         <= '0;
         gpio_int_event <= '0;
      end else if (state == ST_RUN) begin
         filt_d         <= filt;
         gpio_int_event <= (cfg_gpio_posedge_int_sel & filt & ~filt_d) |
                           (cfg_gpio_negedge_int_sel & ~filt & filt_d);
      end else begin
         if (init_done) begin
            filt_d <= sync_ss;
         end
         gpio_int_event <= '0;
      end
   end

endmodule

// File: tb/tb_gpio_intr_gen.sv
// Directed testbench for gpio_intr_gen. Inputs change just after a falling
// edge and outputs are sampled on falling edges; "edge k" below means the
// k-th rising edge after the stimulus change.

module tb_gpio_intr_gen;

   logic        mclk;
   logic        h_reset;
   logic [31:0] gpio_in_data;
   logic [31:0] cfg_deb_en;
   logic [15:0] cfg_deb_presc;
   logic [3:0]  cfg_deb_cnt;
   logic [31:0] cfg_gpio_posedge_int_sel;
   logic [31:0] cfg_gpio_negedge_int_sel;
   logic [31:0] gpio_filt_data;
   logic [31:0] gpio_int_event;
   logic        gen_ready;

   int errors = 0;
   int checks = 0;

   gpio_intr_gen #(.WD(32), .DEB_W(4), .PRESC_W(16)) dut (
      .mclk                     (mclk),
      .h_reset                  (h_reset),
      .gpio_in_data             (gpio_in_data),
      .cfg_deb_en               (cfg_deb_en),
      .cfg_deb_presc            (cfg_deb_presc),
      .cfg_deb_cnt              (cfg_deb_cnt),
      .cfg_gpio_posedge_int_sel (cfg_gpio_posedge_int_sel),
      .cfg_gpio_negedge_int_sel (cfg_gpio_negedge_int_sel),
      .gpio_filt_data           (gpio_filt_data),
      .gpio_int_event           (gpio_int_event),
      .gen_ready                (gen_ready)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   task automatic test_reset();
      h_reset                  = 1'b1;
      gpio_in_data             = 32'hFFFF_0000;
      cfg_deb_en               = 32'h0;
      cfg_deb_presc            = 16'd0;
      cfg_deb_cnt              = 4'd0;
      cfg_gpio_posedge_int_sel = 32'hFFFF_FFFF;
      cfg_gpio_negedge_int_sel = 32'h0;
      repeat (3) @(negedge mclk);
      checks++;
      if (gen_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready got=%b exp=0", gen_ready);
      end
      checks++;
      if (gpio_int_event !== 32'h0) begin
         errors++;
         $display("FAIL reset_event got=%h exp=0", gpio_int_event);
      end
      checks++;
      if (gpio_filt_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_filt got=%h exp=0", gpio_filt_data);
      end
      h_reset = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge mclk);
         checks++;
         if (gen_ready !== (k >= 3)) begin
            errors++;
            $display("FAIL init_ready k=%0d got=%b exp=%b", k, gen_ready, (k >= 3));
         end
         checks++;
         if (gpio_int_event !== 32'h0) begin
            errors++;
            $display("FAIL init_no_event k=%0d got=%h exp=0", k, gpio_int_event);
         end
         if (k >= 3) begin
            checks++;
            if (gpio_filt_data !== 32'hFFFF_0000) begin
               errors++;
               $display("FAIL init_filt k=%0d got=%h exp=ffff0000", k, gpio_filt_data);
            end
         end
      end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_ev;
      cfg_gpio_posedge_int_sel = 32'h20;
      gpio_in_data             = 32'hFFFF_0020;
      for (int k = 1; k <= 6; k++) begin
         @(negedge mclk);
         exp_ev = (k == 4) ? 32'h20 : 32'h0;
         checks++;
         if (gpio_int_event !== exp_ev) begin
            errors++;
            $display("FAIL bypass_event k=%0d got=%h exp=%h", k, gpio_int_event, exp_ev);
         end
         if (k >= 3) begin
            checks++;
            if (gpio_filt_data !== 32'hFFFF_0020) begin
               errors++;
               $display("FAIL bypass_filt k=%0d got=%h exp=ffff0020", k, gpio_filt_data);
            end
         end
      end
   endtask

   // Pin 0: clean debounce. Pin 1: bounce after two ticks restarts the count.
   task automatic test_debounce();
      logic [31:0] exp_ev;
      logic [31:0] exp_filt;
      cfg_deb_en               = 32'h3;
      cfg_deb_presc            = 16'd3;
      cfg_deb_cnt              = 4'd2;
      cfg_gpio_posedge_int_sel = 32'h3;
      gpio_in_data             = 32'hFFFF_0021;
      for (int e = 1; e <= 44; e++) begin
         @(negedge mclk);
         exp_ev   = (e == 13) ? 32'h1 : ((e == 41) ? 32'h2 : 32'h0);
         exp_filt = 32'hFFFF_0020 | ((e >= 12) ? 32'h1 : 32'h0) | ((e >= 40) ? 32'h2 : 32'h0);
         checks++;
         if (gpio_int_event !== exp_ev) begin
            errors++;
            $display("FAIL deb_event e=%0d got=%h exp=%h", e, gpio_int_event, exp_ev);
         end
         checks++;
         if (gpio_filt_data !== exp_filt) begin
            errors++;
            $display("FAIL deb_filt e=%0d got=%h exp=%h", e, gpio_filt_data, exp_filt);
         end
         if (e == 16) gpio_in_data = 32'hFFFF_0023;
         if (e == 24) gpio_in_data = 32'hFFFF_0021;
         if (e == 26) gpio_in_data = 32'hFFFF_0023;
      end
   endtask

   task automatic test_both_edges();
      logic [31:0] exp_ev;
      cfg_deb_en               = 32'h0;
      cfg_deb_presc            = 16'd0;
      cfg_deb_cnt              = 4'd0;
      cfg_gpio_posedge_int_sel = 32'h80;
      cfg_gpio_negedge_int_sel = 32'h80;
      gpio_in_data             = 32'hFFFF_00A3;
      for (int k = 1; k <= 16; k++) begin
         @(negedge mclk);
         exp_ev = (k == 4 || k == 14) ? 32'h80 : 32'h0;
         checks++;
         if (gpio_int_event !== exp_ev) begin
            errors++;
            $display("FAIL both_event k=%0d got=%h exp=%h", k, gpio_int_event, exp_ev);
         end
         if (k == 10) gpio_in_data = 32'hFFFF_0023;
      end
      cfg_gpio_posedge_int_sel = 32'h0;
      cfg_gpio_negedge_int_sel = 32'h0;
      gpio_in_data             = 32'hFFFF_00A3;
      for (int k = 1; k <= 16; k++) begin
         @(negedge mclk);
         checks++;
         if (gpio_int_event !== 32'h0) begin
            errors++;
            $display("FAIL nosel_event k=%0d got=%h exp=0", k, gpio_int_event);
         end
         if (k == 3 || k == 13) begin
            checks++;
            if (gpio_filt_data[7] !== (k == 3)) begin
               errors++;
               $display("FAIL nosel_filt7 k=%0d got=%b exp=%b", k, gpio_filt_data[7], (k == 3));
            end
         end
         if (k == 10) gpio_in_data = 32'hFFFF_0023;
      end
   endtask

   task automatic test_reset_mid();
      cfg_deb_en               = 32'h8;
      cfg_deb_presc            = 16'd3;
      cfg_deb_cnt              = 4'd2;
      cfg_gpio_posedge_int_sel = 32'h8;
      gpio_in_data             = 32'hFFFF_002B;
      for (int k = 1; k <= 5; k++) begin
         @(negedge mclk);
         checks++;
         if (gpio_filt_data[3] !== 1'b0 || gpio_int_event !== 32'h0) begin
            errors++;
            $display("FAIL mid_pending k=%0d filt3=%b event=%h exp filt3=0 event=0", k, gpio_filt_data[3], gpio_int_event);
         end
      end
      h_reset = 1'b1;
      @(negedge mclk);
      checks++;
      if (gen_ready !== 1'b0 || gpio_filt_data !== 32'h0 || gpio_int_event !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset ready=%b filt=%h event=%h exp all 0", gen_ready, gpio_filt_data, gpio_int_event);
      end
      h_reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge mclk);
         checks++;
         if (gen_ready !== (k >= 3)) begin
            errors++;
            $display("FAIL mid_reinit_ready k=%0d got=%b exp=%b", k, gen_ready, (k >= 3));
         end
         checks++;
         if (gpio_int_event !== 32'h0) begin
            errors++;
            $display("FAIL mid_reinit_event k=%0d got=%h exp=0", k, gpio_int_event);
         end
         if (k >= 3) begin
            checks++;
            if (gpio_filt_data !== 32'hFFFF_002B) begin
               errors++;
               $display("FAIL mid_reinit_filt k=%0d got=%h exp=ffff002b", k, gpio_filt_data);
            end
         end
      end
   endtask

   // Prescaler reaches 50 with period 101, then the period drops to 3.
   // Pin 4 with threshold 0 exposes each tick through its filtered level.
   task automatic test_presc_change();
      logic exp_f4;
      h_reset                  = 1'b1;
      cfg_deb_en               = 32'h10;
      cfg_deb_presc            = 16'd100;
      cfg_deb_cnt              = 4'd0;
      cfg_gpio_posedge_int_sel = 32'h0;
      cfg_gpio_negedge_int_sel = 32'h0;
      gpio_in_data             = 32'hFFFF_002B;
      @(negedge mclk);
      h_reset = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge mclk);
         if (k == 3) begin
            checks++;
            if (gen_ready !== 1'b1) begin
               errors++;
               $display("FAIL presc_ready got=%b exp=1", gen_ready);
            end
         end
         if (k == 53 || k == 54 || k == 56 || k == 57 || k == 58 || k == 59 || k == 60) begin
            exp_f4 = (k == 54 || k == 56 || k == 60);
            checks++;
            if (gpio_filt_data[4] !== exp_f4) begin
               errors++;
               $display("FAIL presc_tick k=%0d filt4=%b exp=%b", k, gpio_filt_data[4], exp_f4);
            end
         end
         if (k == 48) gpio_in_data = 32'hFFFF_003B;
         if (k == 53) cfg_deb_presc = 16'd2;
         if (k == 54) gpio_in_data = 32'hFFFF_002B;
         if (k == 57) gpio_in_data = 32'hFFFF_003B;
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_debounce();
      test_both_edges();
      test_reset_mid();
      test_presc_change();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
